// File: rtl/me_pkg.sv
// Shared configuration for the block pixel reader: pixel geometry and FSM encoding.
package me_pkg;

    localparam int DATA_W   = 8;
    localparam int PACK     = 4;
    localparam int ROW_LEN  = 16;
    localparam int BLK_ROWS = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_packer.sv
// Packs PACK consecutive FIFO bytes into one output word, holding it until accepted.
module pixel_packer #(
    parameter int DATA_W = 8,
    parameter int PACK   = 4,
    parameter int FILL_W = $clog2(PACK + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   capture,
    input  logic [DATA_W-1:0]      din,
    input  logic                   out_ready,
    output logic [DATA_W*PACK-1:0] out_data,
    output logic                   out_valid,
    output logic [FILL_W-1:0]      fill,
    output logic                   accept
);

    localparam int WORD_W = DATA_W * PACK;

    logic [WORD_W-1:0] sr;
    logic              load;

    assign accept = out_valid && out_ready;
    assign load   = (fill == FILL_W'(PACK)) && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            fill      <= '0;
        end else if (load) begin
            out_data  <= sr;
            out_valid <= 1'b1;
            fill      <= '0;
        end else begin
            if (accept)
                out_valid <= 1'b0;
            if (capture)
                fill <= fill + FILL_W'(1);
        end
    end

    // NOTE: the shift register carries no reset; fill gates its use and every word is fully rewritten before load.
    always_ff @(posedge clk) begin
        if (capture && !load)
            sr <= {din, sr[WORD_W-1:DATA_W]};
    end

endmodule

// File: rtl/fifo_pixel_reader.sv
// Reads one block of pixels from a FIFO and emits packed words with row/block markers.
module fifo_pixel_reader
    import me_pkg::*;
#(
    parameter int DATA_W   = me_pkg::DATA_W,
    parameter int PACK     = me_pkg::PACK,
    parameter int ROW_LEN  = me_pkg::ROW_LEN,
    parameter int BLK_ROWS = me_pkg::BLK_ROWS
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   fifo_empty,
    input  logic [DATA_W-1:0]      fifo_data,
    output logic                   fifo_rd,
    output logic [DATA_W*PACK-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last_row,
    output logic                   out_last_blk,
    output logic                   busy,
    output logic                   done
);

    localparam int TOTAL  = ROW_LEN * BLK_ROWS;
    localparam int WORDS  = TOTAL / PACK;
    localparam int WPR    = ROW_LEN / PACK;
    localparam int REQ_W  = $clog2(TOTAL + 1);
    localparam int WORD_W = $clog2(WORDS);
    localparam int FILL_W = $clog2(PACK + 1);

    localparam logic [REQ_W-1:0]  REQ_MAX   = REQ_W'(TOTAL);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
    localparam logic [WORD_W-1:0] ROW_WORDS = WORD_W'(WPR);
    localparam logic [WORD_W-1:0] ROW_LAST  = WORD_W'(WPR - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PACK);

    state_t              state, state_nxt;
    logic [REQ_W-1:0]    req_cnt;
    logic [WORD_W-1:0]   word_cnt;
    logic                pend;
    logic [FILL_W-1:0]   fill;
    logic                accept;
    logic                last_accept;

    // A byte still in flight counts against packer space so the packer never overflows.
    assign fifo_rd = (state == READ) && !fifo_empty && (req_cnt < REQ_MAX)
                   && ((fill + FILL_W'(pend)) < FILL_FULL);

    assign out_last_row = out_valid && ((word_cnt % ROW_WORDS) == ROW_LAST);
    assign out_last_blk = out_valid && (word_cnt == WORD_LAST);
    assign last_accept  = accept && out_last_blk;
    assign busy         = (state != IDLE);

    // NOTE: next-state defaults to the current state first, so no path leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start)               state_nxt = READ;
            READ:    if (req_cnt == REQ_MAX)  state_nxt = FLUSH;
            FLUSH:   if (last_accept)         state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    // NOTE: all state updates use <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_cnt  <= '0;
            word_cnt <= '0;
            pend     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= fifo_rd;
            done  <= last_accept;
            if (last_accept)
                req_cnt <= '0;
            else if (fifo_rd)
                req_cnt <= req_cnt + REQ_W'(1);
            if (accept)
                word_cnt <= last_accept ? '0 : word_cnt + WORD_W'(1);
        end
    end

    pixel_packer #(
        .DATA_W (DATA_W),
        .PACK   (PACK),
        .FILL_W (FILL_W)
    ) u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (pend),
        .din       (fifo_data),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .fill      (fill),
        .accept    (accept)
    );

endmodule

// File: tb/tb_fifo_pixel_reader.sv
// Directed bench for fifo_pixel_reader with a behavioural FIFO and accepted-word recorder.
module tb_fifo_pixel_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_data  = '0;
    logic        fifo_rd;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last_row;
    logic        out_last_blk;
    logic        busy;
    logic        done;

    fifo_pixel_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_rd      (fifo_rd),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last_row (out_last_row),
        .out_last_blk (out_last_blk),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  q[$];
    logic [63:0] got_w[$];
    int          acc_cyc[$];
    int          cyc = 0;
    int          rd_cnt, viol, done_cnt, done_cyc, last_acc_cyc;
    logic        tog = 1'b0;
    logic        tog_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model (data one cycle after pop) plus recorder of accepted words.
    always @(posedge clk) begin
        if (fifo_rd) begin
            rd_cnt++;
            if (fifo_empty) viol++;
            if (q.size() == 0) viol++;
            else fifo_data <= q.pop_front();
        end
        if (out_valid && out_ready) begin
            got_w.push_back({30'd0, out_last_blk, out_last_row, out_data});
            acc_cyc.push_back(cyc);
            if (out_last_blk) last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        tog        <= ~tog;
        fifo_empty <= (q.size() == 0) || (tog_mode && !tog);
        cyc++;
    end

    function automatic logic [7:0] pat(input int sel, input int i);
        if (sel == 0) return 8'(i);
        return 8'(i * 7 + 3);
    endfunction

    function automatic logic [63:0] exp_word(input int sel, input int i);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = pat(sel, 4 * i + k);
        return {30'd0, (i == 63), (i % 4 == 3), d};
    endfunction

    task automatic clear_mon();
        rd_cnt = 0; viol = 0; done_cnt = 0; done_cyc = 0; last_acc_cyc = -100;
        got_w.delete();
        acc_cyc.delete();
    endtask

    task automatic load_fifo(input int sel);
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(pat(sel, i));
    endtask

    task automatic start_block();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 4000 && done_cnt == 0; n++) @(negedge clk);
        if (done_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            check({tag, "_busy_after_done"}, busy, 0);
            check({tag, "_valid_after_done"}, out_valid, 0);
        end
    endtask

    task automatic check_block(input string tag, input int sel);
        check({tag, "_word_count"}, got_w.size(), 64);
        for (int i = 0; i < got_w.size() && i < 64; i++)
            check($sformatf("%s_w%0d", tag, i), got_w[i], exp_word(sel, i));
        check({tag, "_rd_pulses"}, rd_cnt, 256);
        check({tag, "_rd_while_empty"}, viol, 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_delay"}, done_cyc - last_acc_cyc, 1);
        check({tag, "_fifo_drained"}, q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
        clear_mon();
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_done", done, 0);
        check("rst_data", out_data, 0);
        rst_n = 1'b1;

        // Block A: ramp data, full throughput, stray start while busy.
        @(negedge clk);
        clear_mon();
        load_fifo(0);
        start_block();
        repeat (20) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("A");
        repeat (20) @(negedge clk);
        check("A_no_restart", busy, 0);
        check_block("A", 0);
        if (acc_cyc.size() > 2) check("A_word_period", acc_cyc[2] - acc_cyc[1], 6);
        else check("A_word_period", acc_cyc.size(), 3);

        // Block B: consumer stalls 10 cycles while a word is held.
        clear_mon();
        load_fifo(1);
        start_block();
        repeat (30) @(negedge clk);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clk);
        begin
            logic [63:0] held;
            int bad_data, valid_low, rd_late;
            held = exp_word(1, got_w.size());
            bad_data = 0; valid_low = 0; rd_late = 0;
            out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_data !== held[31:0]) bad_data++;
                if (out_valid !== 1'b1) valid_low++;
                if (i >= 3 && fifo_rd) rd_late++;
            end
            out_ready = 1'b1;
            check("B_stall_data_stable", bad_data, 0);
            check("B_stall_valid_held", valid_low, 0);
            check("B_stall_rd_stopped", rd_late, 0);
        end
        wait_done("B");
        check_block("B", 1);

        // Block C: FIFO empty flag toggling every other cycle.
        clear_mon();
        tog_mode = 1'b1;
        load_fifo(0);
        start_block();
        wait_done("C");
        check_block("C", 0);
        tog_mode = 1'b0;

        // Reset mid-block with two bytes packed and one in flight.
        clear_mon();
        load_fifo(0);
        start_block();
        for (int n = 0; n < 20 && !fifo_rd; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_fifo_rd", fifo_rd, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_flags", {out_last_row, out_last_blk}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        load_fifo(0);
        start_block();
        wait_done("D");
        check_block("D", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
